knn_sequencer: RTL and testbench
================================

// Module: knn_sequencer
// PURPOSE
//  Top-level control FSM for one KNN query. It streams N stored samples from sample memory into the
//  top-K selector, then replays the K winning tags into the majority-vote classifier and returns the class.
//  It sits between the host/start logic and the memory -> selector -> classifier datapath.
// PARAMETERS
//  TAG       2     tag (class) bits per sample
//  WIDTH     4     feature bits per sample
//  MEM_SIZE  1024  sample-memory depth; CW = $clog2(MEM_SIZE)
// PORTS
//  clk_i         in   1          single clock, all logic on posedge
//  rst_i         in   1          synchronous, active-high reset
//  start_i       in   1          query request, sampled only in IDLE
//  k_i           in   CW         neighbours to vote, latched at start
//  n_samples_i   in   CW+1       samples to scan (1..MEM_SIZE), latched at start
//  mem_rd_o      out  1          sample-memory read strobe
//  mem_addr_o    out  CW         read address; data returns next cycle
//  mem_data_i    in   TAG+WIDTH  read data, valid 1 cycle after mem_rd_o
//  sel_valid_o   out  1          sample valid to top-K selector
//  sel_data_o    out  TAG+WIDTH  sample to selector
//  sel_last_o    out  1          marks sample N-1 (qualified by sel_valid_o)
//  sel_ready_i   in   1          selector accepts when sel_valid_o & sel_ready_i
//  sel_done_i    in   1          selector finished ranking (pulse or level)
//  sel_rd_o      out  1          read of the ranked-tag list
//  sel_idx_o     out  CW         rank index 0..K-1; sel_tag_i valid next cycle
//  sel_tag_i     in   TAG        tag of ranked neighbour
//  cls_rst_o     out  1          classifier clear
//  cls_start_o   out  1          classifier count enable
//  cls_data_o    out  TAG+WIDTH  {tag, WIDTH'0} to classifier
//  cls_k_o       out  CW         latched K to classifier
//  cls_done_i    in   1          classifier result ready
//  cls_class_i   in   TAG        classifier result
//  busy_o        out  1          high from the accepted start until done_o
//  done_o        out  1          one-cycle completion pulse
//  err_o         out  1          valid with done_o: query rejected
//  class_o       out  TAG        result; held until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0 except cls_rst_o. cls_rst_o = rst_i | (state==CLR), so the
//   classifier is cleared with us. Reset mid-query aborts the query at once; no done_o.
//  IDLE: start_i=1 latches k_i/n_samples_i and sets busy_o. If K==0, N==0 or K>N: go to DONE with err_o=1,
//   class_o=0, and no memory traffic. Otherwise go to FETCH. start_i while busy is ignored (no queueing).
//  FETCH: addresses 0..N-1 are issued in order. A read is issued only when the 1-entry hold register is empty
//   or is being drained this cycle, giving one sample/cycle at steady state with sel_ready_i=1.
//   sel_valid_o/sel_data_o/sel_last_o stay stable while sel_ready_i=0. After the last handshake go to RANK.
//  RANK: wait for sel_done_i, then go to CLR.
//  CLR: cls_rst_o=1 for exactly one cycle, then go to REPLAY.
//  REPLAY: sel_rd_o for idx 0..K-1 on consecutive cycles. Each returned tag drives cls_start_o=1 and
//   cls_data_o for exactly one cycle, so cls_start_o is high for exactly K consecutive cycles. Then go to WAIT.
//  WAIT: on cls_done_i, capture class_o=cls_class_i and go to DONE. No timeout.
//  DONE: done_o=1 and busy_o=0 in this single cycle, then go to IDLE. done_o is never asserted twice per query.
//  Counters are CW+1 bits, so N=MEM_SIZE does not wrap. The last address is N-1 and the last rank is K-1.
//  Simultaneous sel_ready_i and hold-register refill in the same cycle is legal and loses no sample.
// STRUCTURE
//  knn_pkg: state enum (IDLE, FETCH, RANK, CLR, REPLAY, WAIT, DONE), CW localparam function, sample_t struct {tag, feat}.
//  Sub-module knn_fetch_skid: the 1-entry hold register plus valid/ready logic for FETCH. The FSM stays in knn_sequencer.
// TESTING
//  N=8, K=3, sel_ready_i=1 -> addr 0..7 on 8 consecutive cycles; sel_last_o with sample 7; cls_start_o high 3 cycles.
//  Same query, sel_ready_i toggling 1/0 -> the 8 samples reach the selector once each, in order, data stable while stalled.
//  K=0, N=5 -> done_o and err_o 1 cycle after start; mem_rd_o never asserted. Repeat with K=6, N=5.
//  N=MEM_SIZE=1024, K=1 -> addr reaches 1023 with no wrap; exactly 1024 handshakes.
//  Ranked tags {2,2,1}, classifier model -> class_o=2 with done_o; class_o holds through the next IDLE cycles.
//  rst_i asserted in REPLAY -> next cycle IDLE, all outputs 0, cls_rst_o=1; a new start then completes normally.

Source files
------------

// File: rtl/knn_sequencer_pkg.sv
// Shared types and constants for the KNN query sequencer.
// Contents:
//   TAG, WIDTH, MEM_SIZE  sample geometry and sample-memory depth
//   CW                    address / rank-index width
//   state_e               sequencer FSM states
//   sample_t              {tag, feat} sample record
//   idx_t, cnt_t          CW-bit index and CW+1-bit counter types
//   query_bad()           start-time rejection test for K and N
package knn_sequencer_pkg;

    localparam int unsigned TAG      = 2;
    localparam int unsigned WIDTH    = 4;
    localparam int unsigned MEM_SIZE = 1024;
    localparam int unsigned CW       = $clog2(MEM_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StRank,
        StClr,
        StReplay,
        StWait,
        StDone
    } state_e;

    typedef struct packed {
        logic [TAG-1:0]   tag;
        logic [WIDTH-1:0] feat;
    } sample_t;

    typedef logic [CW-1:0] idx_t;
    // One extra bit so that N = MEM_SIZE is representable without wrapping.
    typedef logic [CW:0]   cnt_t;

    // A query is rejected when there is nothing to scan, nothing to vote,
    // or more voters than samples.
    function automatic logic query_bad(input idx_t k, input cnt_t n);
        return (k == '0) || (n == '0) || ({1'b0, k} > n);
    endfunction

endpackage

// File: rtl/knn_sequencer_if.sv
// Datapath-facing bundle of the KNN sequencer: sample-memory read port, top-K selector
// stream and ranked-tag read port, and classifier control.
// Modports:
//   master  the sequencer (drives mem_rd/addr, sel_*_o, cls_*_o)
//   slave   the memory / selector / classifier side
interface knn_sequencer_if;
    import knn_sequencer_pkg::*;

    // Sample memory
    logic           mem_rd_o;
    idx_t           mem_addr_o;
    sample_t        mem_data_i;
    // Top-K selector
    logic           sel_valid_o;
    sample_t        sel_data_o;
    logic           sel_last_o;
    logic           sel_ready_i;
    logic           sel_done_i;
    logic           sel_rd_o;
    idx_t           sel_idx_o;
    logic [TAG-1:0] sel_tag_i;
    // Majority-vote classifier
    logic           cls_rst_o;
    logic           cls_start_o;
    sample_t        cls_data_o;
    idx_t           cls_k_o;
    logic           cls_done_i;
    logic [TAG-1:0] cls_class_i;

    modport master (
        output mem_rd_o, mem_addr_o,
        input  mem_data_i,
        output sel_valid_o, sel_data_o, sel_last_o,
        input  sel_ready_i, sel_done_i,
        output sel_rd_o, sel_idx_o,
        input  sel_tag_i,
        output cls_rst_o, cls_start_o, cls_data_o, cls_k_o,
        input  cls_done_i, cls_class_i
    );

    modport slave (
        input  mem_rd_o, mem_addr_o,
        output mem_data_i,
        input  sel_valid_o, sel_data_o, sel_last_o,
        output sel_ready_i, sel_done_i,
        input  sel_rd_o, sel_idx_o,
        output sel_tag_i,
        input  cls_rst_o, cls_start_o, cls_data_o, cls_k_o,
        output cls_done_i, cls_class_i
    );

endinterface

// File: rtl/knn_fetch_skid.sv
// One-entry hold buffer between the sample memory (1-cycle read latency) and the
// top-K selector's valid/ready input.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   rd_i           a memory read is issued this cycle
//   ready_i        selector ready
//   mem_data_i     memory read data (valid the cycle after rd_i)
//   valid_o        sample available to the selector
//   data_o         sample to the selector (0 when not valid)
//   issue_ok_o     a new read may be issued this cycle without losing data
module knn_fetch_skid
    import knn_sequencer_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    rd_i,
    input  logic    ready_i,
    input  sample_t mem_data_i,
    output logic    valid_o,
    output sample_t data_o,
    output logic    issue_ok_o
);

    // The single entry is either still on the memory bus (pend_q) or parked in
    // hold_q; the two are never set together.
    logic    pend_q;
    logic    hold_valid_q;
    sample_t hold_q;
    logic    occ;

    always_comb begin
        occ        = pend_q | hold_valid_q;
        valid_o    = occ;
        data_o     = hold_valid_q ? hold_q : (pend_q ? mem_data_i : '0);
        // Refill is allowed when empty or when the entry drains this cycle.
        issue_ok_o = !occ || ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q       <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            pend_q <= rd_i;
            if (pend_q && !ready_i) begin
                // Stalled: park the returning word so the output stays stable.
                hold_q       <= mem_data_i;
                hold_valid_q <= 1'b1;
            end else if (ready_i) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/knn_sequencer.sv
// Control FSM for one KNN query: streams N samples from sample memory into the top-K
// selector, replays the K ranked tags into the majority-vote classifier, returns the class.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (aborts any query)
//   start_i             query request, sampled only when idle
//   k_i, n_samples_i    neighbour count and sample count, latched at start
//   bus                 memory / selector / classifier bundle (master side)
//   busy_o              query in progress
//   done_o              one-cycle completion pulse
//   err_o               with done_o: query was rejected
//   class_o             result, held until the next accepted start
module knn_sequencer
    import knn_sequencer_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  idx_t            k_i,
    input  cnt_t            n_samples_i,
    knn_sequencer_if.master bus,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [TAG-1:0]  class_o
);

    state_e         state_q;
    idx_t           k_q;
    cnt_t           n_q;
    cnt_t           iss_q;     // reads issued
    cnt_t           acc_q;     // samples accepted by the selector
    cnt_t           idx_q;     // ranks requested during replay
    logic           tag_pend_q;
    logic           err_q;
    logic [TAG-1:0] class_q;

    logic    issue_ok;
    logic    skid_valid;
    sample_t skid_data;
    logic    mem_rd;
    logic    sel_hs;
    logic    sel_last;
    logic    sel_rd;

    always_comb begin
        mem_rd   = (state_q == StFetch) && (iss_q < n_q) && issue_ok;
        sel_hs   = skid_valid && bus.sel_ready_i;
        sel_last = skid_valid && (acc_q == n_q - cnt_t'(1));
        // Replay is left right after rank K-1 is requested, so every replay cycle reads.
        sel_rd   = (state_q == StReplay);
    end

    knn_fetch_skid u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_i       (mem_rd),
        .ready_i    (bus.sel_ready_i),
        .mem_data_i (bus.mem_data_i),
        .valid_o    (skid_valid),
        .data_o     (skid_data),
        .issue_ok_o (issue_ok)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            k_q        <= '0;
            n_q        <= '0;
            iss_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            tag_pend_q <= 1'b0;
            err_q      <= 1'b0;
            class_q    <= '0;
        end else begin
            // The ranked tag returns one cycle after its read.
            tag_pend_q <= sel_rd;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        k_q     <= k_i;
                        n_q     <= n_samples_i;
                        iss_q   <= '0;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        class_q <= '0;
                        if (query_bad(k_i, n_samples_i)) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= StFetch;
                        end
                    end
                end
                StFetch: begin
                    if (mem_rd) iss_q <= iss_q + cnt_t'(1);
                    if (sel_hs) acc_q <= acc_q + cnt_t'(1);
                    if (sel_hs && sel_last) state_q <= StRank;
                end
                StRank: begin
                    if (bus.sel_done_i) state_q <= StClr;
                end
                StClr: begin
                    state_q <= StReplay;
                end
                StReplay: begin
                    idx_q <= idx_q + cnt_t'(1);
                    if (idx_q == {1'b0, k_q} - cnt_t'(1)) state_q <= StWait;
                end
                StWait: begin
                    if (bus.cls_done_i) begin
                        class_q <= bus.cls_class_i;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_rd_o    = mem_rd;
        bus.mem_addr_o  = mem_rd ? iss_q[CW-1:0] : '0;
        bus.sel_valid_o = skid_valid;
        bus.sel_data_o  = skid_data;
        bus.sel_last_o  = sel_last;
        bus.sel_rd_o    = sel_rd;
        bus.sel_idx_o   = sel_rd ? idx_q[CW-1:0] : '0;
        // Classifier is cleared together with this block and once per query.
        bus.cls_rst_o   = rst_i || (state_q == StClr);
        bus.cls_start_o = tag_pend_q;
        bus.cls_data_o  = '0;
        if (tag_pend_q) begin
            bus.cls_data_o.tag = bus.sel_tag_i;
        end
        bus.cls_k_o     = k_q;
        busy_o          = (state_q == StFetch) || (state_q == StRank) || (state_q == StClr) ||
                          (state_q == StReplay) || (state_q == StWait);
        done_o          = (state_q == StDone);
        err_o           = (state_q == StDone) && err_q;
        class_o         = class_q;
    end

endmodule

// File: tb/tb_knn_sequencer.sv
module tb_knn_sequencer;
    import knn_sequencer_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    idx_t           k;
    cnt_t           n;
    logic           busy;
    logic           done;
    logic           err;
    logic [TAG-1:0] cls;

    knn_sequencer_if bus();

    knn_sequencer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .k_i         (k),
        .n_samples_i (n),
        .bus         (bus),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .class_o     (cls)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  k;
        int                  n;
        bit                  tog;     // sel_ready toggles 1/0
        bit                  poke;    // extra start pulse while busy
        logic [7:0][TAG-1:0] tags;    // ranked tags, index 0 = best
        bit                  exp_err;
        int                  exp_class;
    } vec_t;

    int n_checks = 0;
    int n_miss   = 0;

    bit                  toggle_mode = 1'b0;
    logic [7:0][TAG-1:0] rank_tags   = '0;

    function automatic sample_t pat(input int a);
        logic [5:0] v;
        v = 6'(a * 7 + 3);
        return sample_t'(v);
    endfunction

    // ---------------- environment models (memory, selector, classifier) ----------------
    int votes [4];
    int ccnt;

    always @(posedge clk) begin
        if (rst) begin
            bus.mem_data_i  <= '0;
            bus.sel_ready_i <= 1'b1;
            bus.sel_done_i  <= 1'b0;
            bus.sel_tag_i   <= '0;
        end else begin
            if (bus.mem_rd_o) bus.mem_data_i <= pat(int'(bus.mem_addr_o));
            bus.sel_ready_i <= toggle_mode ? ~bus.sel_ready_i : 1'b1;
            bus.sel_done_i  <= bus.sel_valid_o & bus.sel_ready_i & bus.sel_last_o;
            if (bus.sel_rd_o) bus.sel_tag_i <= rank_tags[bus.sel_idx_o[2:0]];
        end
    end

    always @(posedge clk) begin
        int b;
        if (bus.cls_rst_o) begin
            for (int t = 0; t < 4; t++) votes[t] <= 0;
            ccnt            <= 0;
            bus.cls_done_i  <= 1'b0;
            bus.cls_class_i <= '0;
        end else begin
            if (bus.cls_start_o) begin
                votes[bus.cls_data_o.tag] <= votes[bus.cls_data_o.tag] + 1;
                ccnt <= ccnt + 1;
            end
            bus.cls_done_i <= (ccnt != 0) && (ccnt == int'(bus.cls_k_o));
            b = 0;
            for (int t = 1; t < 4; t++) if (votes[t] > votes[b]) b = t;
            bus.cls_class_i <= TAG'(b);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.mem_rd_o, bus.mem_addr_o, bus.sel_valid_o, bus.sel_data_o,
                    bus.sel_last_o, bus.sel_rd_o, bus.sel_idx_o, bus.cls_start_o,
                    bus.cls_data_o, bus.cls_k_o, busy, done, err, cls, bus.cls_rst_o});
    endfunction

    function automatic vec_t mkv(input int kk, input int nn, input bit tg, input bit pk,
                                 input int t0, input int t1, input int t2, input int t3,
                                 input int t4, input bit e, input int c);
        vec_t v;
        v.k = kk; v.n = nn; v.tog = tg; v.poke = pk;
        v.tags = '0;
        v.tags[0] = TAG'(t0); v.tags[1] = TAG'(t1); v.tags[2] = TAG'(t2);
        v.tags[3] = TAG'(t3); v.tags[4] = TAG'(t4);
        v.exp_err = e; v.exp_class = c;
        return v;
    endfunction

    // Run one query at negedge granularity, monitoring the whole stream, then check it.
    task automatic run_query(input vec_t v, input string nm);
        int rd = 0, hs = 0, starts = 0, runs = 0, cyc = 0, lat = -1;
        int addr_e = 0, order_e = 0, stab_e = 0, clsd_e = 0, hold_e = 0;
        int first_rd = 0, last_rd = 0, last_addr = -1;
        bit prev_start = 0, stall_pend = 0, got_done = 0;
        int got_err = -1, got_cls = -1, got_busy = -1;
        sample_t stall_data = '0;
        sample_t exp_cd;

        @(negedge clk);
        toggle_mode = v.tog;
        rank_tags   = v.tags;
        k           = idx_t'(v.k);
        n           = cnt_t'(v.n);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!got_done && cyc < 5000) begin
            if (v.poke) begin
                start = (cyc == 3);
                if (cyc == 3) begin k = '0; n = cnt_t'(5); end
            end
            if (bus.mem_rd_o) begin
                if (int'(bus.mem_addr_o) != rd % MEM_SIZE) addr_e++;
                if (rd == 0) first_rd = cyc;
                last_rd   = cyc;
                last_addr = int'(bus.mem_addr_o);
                rd++;
            end
            if (stall_pend && (!bus.sel_valid_o || bus.sel_data_o != stall_data)) stab_e++;
            if (bus.sel_valid_o && bus.sel_ready_i) begin
                if (bus.sel_data_o != pat(hs)) order_e++;
                if (bus.sel_last_o != (hs == v.n - 1)) order_e++;
                hs++;
                stall_pend = 0;
            end else if (bus.sel_valid_o) begin
                stall_pend = 1;
                stall_data = bus.sel_data_o;
            end else begin
                stall_pend = 0;
            end
            if (bus.cls_start_o) begin
                exp_cd = '0;
                if (starts < 8) exp_cd.tag = v.tags[starts];
                if (bus.cls_data_o != exp_cd) clsd_e++;
                if (!prev_start) runs++;
                starts++;
            end
            prev_start = bus.cls_start_o;
            if (done) begin
                got_done = 1;
                got_err  = int'(err);
                got_cls  = int'(cls);
                got_busy = int'(busy);
                lat      = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check({nm, " done_seen"}, got_done, 1);
        check({nm, " err"}, got_err, v.exp_err);
        check({nm, " class_at_done"}, got_cls, v.exp_class);
        check({nm, " busy_at_done"}, got_busy, 0);
        check({nm, " mem_reads"}, rd, v.exp_err ? 0 : v.n);
        check({nm, " handshakes"}, hs, v.exp_err ? 0 : v.n);
        check({nm, " cls_start_cycles"}, starts, v.exp_err ? 0 : v.k);
        if (v.exp_err) begin
            check({nm, " err_latency"}, lat, 0);
        end else begin
            check({nm, " addr_order"}, addr_e, 0);
            check({nm, " last_addr"}, last_addr, v.n - 1);
            check({nm, " sample_order"}, order_e, 0);
            check({nm, " stall_stability"}, stab_e, 0);
            check({nm, " cls_start_runs"}, runs, 1);
            check({nm, " cls_data"}, clsd_e, 0);
            if (!v.tog) check({nm, " rd_consecutive"}, last_rd - first_rd, v.n - 1);
        end
        // Result holds and done_o stays low through the following idle cycles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy || int'(cls) != v.exp_class) hold_e++;
        end
        check({nm, " hold_after_done"}, hold_e, 0);
    endtask

    vec_t vecs [10];

    initial begin
        int seen;
        bit found;

        vecs[0] = mkv(3, 8,    0, 0, 2, 2, 1, 0, 0, 0, 2);
        vecs[1] = mkv(3, 8,    1, 0, 1, 3, 3, 0, 0, 0, 3);
        vecs[2] = mkv(0, 5,    0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[3] = mkv(6, 5,    0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[4] = mkv(1, 1024, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        vecs[5] = mkv(5, 5,    1, 0, 0, 1, 0, 3, 0, 0, 0);
        vecs[6] = mkv(3, 0,    0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[7] = mkv(4, 2,    1, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[8] = mkv(2, 3,    1, 0, 3, 3, 0, 0, 0, 0, 3);
        vecs[9] = mkv(3, 8,    0, 1, 2, 2, 1, 0, 0, 0, 2);

        rst   = 1'b1;
        start = 1'b0;
        k     = '0;
        n     = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", all_outs(), 64'd0);

        for (int i = 0; i < 10; i++) run_query(vecs[i], $sformatf("vec%0d", i));

        // Reset while replaying ranked tags: aborts with no done_o.
        @(negedge clk);
        toggle_mode = 1'b0;
        rank_tags   = vecs[0].tags;
        k           = idx_t'(3);
        n           = cnt_t'(8);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (bus.sel_rd_o) found = 1;
            else @(negedge clk);
        end
        check("reach_replay", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("reset_in_replay_outputs", all_outs(), 64'd1);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("no_done_after_abort", seen, 0);
        run_query(vecs[0], "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

endmodule
